// File: rtl/seq_transmit.sv
// -----------------------------------------------------------------------------
// seq_transmit
//   Serial pattern transmitter. A latched N-bit pattern is shifted out MSB
//   first, one bit per clock, on a single registered line. The frame can be
//   repeated `rep` times with GAP idle (a=0) cycles between frames. The bit
//   order is the one a shift-left receiver comparing its last N bits against
//   the same pattern expects, so a loopback yields a detection.
//
// Optional feature (compile-time macro SEQ_TX_PARITY_EN):
//   when defined, every frame carries one extra trailing bit, the even parity
//   of the latched pattern. Undefined (default): frames are exactly N bits.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   start  in   transmit request, accepted only while ready=1
//   seq    in   [N-1:0] pattern, sampled at acceptance only
//   rep    in   [REP_W-1:0] frame count, 0 behaves as 1
//   a      out  serial data (registered)
//   ready  out  high in IDLE; a start is accepted in this cycle
//   busy   out  high while sending frames or gaps
//   done   out  one-cycle pulse in the first IDLE cycle after the last frame
// -----------------------------------------------------------------------------
module seq_transmit #(
    parameter int N     = 6,
    parameter int GAP   = 2,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     seq,
    input  logic [REP_W-1:0] rep,
    output logic             a,
    output logic             ready,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = N + 1;
`else
    localparam int FRAME_LEN = N;
`endif
    localparam int BW = $clog2(FRAME_LEN);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BW-1:0]    LAST_BIT = BW'(FRAME_LEN - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    state_e           state_q,    state_d;
    logic [N-1:0]     shreg_q,    shreg_d;
    logic [N-1:0]     hold_q,     hold_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q,  gap_cnt_d;
    logic [REP_W-1:0] rep_left_q, rep_left_d;
    logic             done_q,     done_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;

    // The line is the MSB of the shift register. The register is empty
    // (all zero) whenever the FSM is in IDLE or GAP, because every frame
    // shifts all of its bits out before leaving SEND.
    assign a     = shreg_q[N-1];
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // NOTE: every signal driven here gets its default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rep_left_d = rep_left_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d    = seq;
                    hold_d     = seq;
                    rep_left_d = (rep == '0) ? REP_ONE : rep;
                    bit_cnt_d  = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                shreg_d   = {shreg_q[N-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef SEQ_TX_PARITY_EN
                // After seq[0] the parity bit is queued as the only bit left.
                if (bit_cnt_q == BW'(N - 1)) begin
                    shreg_d = {^hold_q, {(N-1){1'b0}}};
                end
`endif
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (rep_left_q > REP_ONE) begin
                        rep_left_d = rep_left_q - REP_ONE;
                        if (GAP > 0) begin
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end else begin
                            // Back-to-back frames: reload without an idle cycle.
                            shreg_d = hold_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    shreg_d   = hold_q;
                    bit_cnt_d = '0;
                    state_d   = ST_SEND;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            rep_left_q <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rep_left_q <= rep_left_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_seq_transmit.sv
// -----------------------------------------------------------------------------
// tb_seq_transmit
//   Directed bench for seq_transmit. Two instances share clock and reset:
//   u_dut with GAP=2 (main tests) and u_dut0 with GAP=0 feeding a small
//   shift-left pattern receiver model (loopback test). Inputs are driven and
//   outputs sampled on the falling edge; "cycle c" is the interval after the
//   c-th rising edge counted from the start request. Honours SEQ_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_seq_transmit;

    localparam int N     = 6;
    localparam int GAP   = 2;
    localparam int REP_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int FL        = N + 1;
    localparam int DONE_ONE  = 8;
    localparam int DONE_REP3 = 26;
`else
    localparam int FL        = N;
    localparam int DONE_ONE  = 7;
    localparam int DONE_REP3 = 23;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start,  start0;
    logic [N-1:0]     seq,    seq0;
    logic [REP_W-1:0] rep,    rep0;
    logic             a,      a0;
    logic             ready,  ready0;
    logic             busy,   busy0;
    logic             done,   done0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_transmit #(.N(N), .GAP(GAP), .REP_W(REP_W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .seq(seq), .rep(rep),
        .a(a), .ready(ready), .busy(busy), .done(done)
    );

    seq_transmit #(.N(N), .GAP(0), .REP_W(REP_W)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .seq(seq0), .rep(rep0),
        .a(a0), .ready(ready0), .busy(busy0), .done(done0)
    );

    // Receiver model: shift left, compare last N bits to the pattern.
    localparam logic [N-1:0] LB_PAT = 6'b101101;
    logic [N-1:0] det_q;
    logic         det_valid;
    always @(posedge clk) begin
        if (reset) det_q <= '0;
        else       det_q <= {det_q[N-2:0], a0};
    end
    assign det_valid = (det_q == LB_PAT);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Expected line value for frame position i of pattern s.
    function automatic logic bit_of(input logic [N-1:0] s, input int i);
        if (i < N) return s[N-1-i];
        return ^s;
    endfunction

    // Start a transfer from an idle cycle and follow it to the done pulse.
    task automatic run_tx(input string tag, input logic [N-1:0] s,
                          input logic [REP_W-1:0] r_in, input int r_eff, input int exp_done);
        int c0;
        c0    = cyc;
        start = 1'b1;
        seq   = s;
        rep   = r_in;
        step();
        start = 1'b0;
        seq   = ~s;      // ignored while busy
        rep   = '1;      // ignored while busy
        for (int f = 0; f < r_eff; f++) begin
            for (int i = 0; i < FL; i++) begin
                check({tag, "_a"}, a, bit_of(s, i));
                check({tag, "_busy"}, busy, 1);
                check({tag, "_done_early"}, done, 0);
                step();
            end
            if (f < r_eff - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    check({tag, "_gap_a"}, a, 0);
                    check({tag, "_gap_busy"}, busy, 1);
                    step();
                end
            end
        end
        check({tag, "_done_cycle"}, cyc - c0, exp_done);
        check({tag, "_done"}, done, 1);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_idle_a"}, a, 0);
        check({tag, "_idle_busy"}, busy, 0);
        step();
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;  seq  = '0;  rep  = '0;
        start0 = 1'b0;  seq0 = '0;  rep0 = '0;
        step();
        step();
        check("rst_a", a, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        step();

        // Single frame.
        run_tx("one", 6'b101100, 4'd1, 1, DONE_ONE);

        // Three frames separated by gaps, one done pulse at the end.
        run_tx("rep3", 6'b110011, 4'd3, 3, DONE_REP3);

        // rep=0 behaves as rep=1; start held high is only re-accepted at done.
        start = 1'b1;
        seq   = 6'b000001;
        rep   = '0;
        step();
        seq = 6'b111111;
        for (int i = 0; i < FL; i++) begin
            check("rep0_a", a, bit_of(6'b000001, i));
            check("rep0_busy", busy, 1);
            check("rep0_done_early", done, 0);
            step();
        end
        check("rep0_done", done, 1);
        check("rep0_ready", ready, 1);
        step();
        start = 1'b0;
        check("rep0_restart_busy", busy, 1);
        check("rep0_restart_a", a, 1);
        for (int i = 0; i < FL; i++) step();
        check("rep0_restart_done", done, 1);
        step();

        // Reset during the third bit.
        start = 1'b1;
        seq   = 6'b101100;
        rep   = 4'd1;
        step();
        start = 1'b0;
        check("rst_mid_b1", a, 1);
        step();
        check("rst_mid_b2", a, 0);
        step();
        check("rst_mid_b3", a, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_a", a, 0);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        for (int i = 0; i < 8; i++) begin
            check("rst_mid_no_done", done, 0);
            step();
        end
        run_tx("after_rst", 6'b101100, 4'd1, 1, DONE_ONE);

        // Loopback: back-to-back frames into the receiver model.
        start0 = 1'b1;
        seq0   = LB_PAT;
        rep0   = 4'd2;
        step();
        start0 = 1'b0;
        seq0   = '0;
        for (int c = 1; c <= 2 * FL + 1; c++) begin
            if (c <= 2 * FL) begin
                check("lb_a", a0, bit_of(LB_PAT, (c - 1) % FL));
                check("lb_busy", busy0, 1);
                check("lb_done_early", done0, 0);
            end
            if (c == N + 1)      check("lb_det1", det_valid, 1);
            if (c == FL + N + 1) check("lb_det2", det_valid, 1);
            if (c == 2 * FL + 1) begin
                check("lb_done", done0, 1);
                check("lb_ready", ready0, 1);
            end
            step();
        end
        check("lb_done_once", done0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_transmit.md
Name: seq_transmit

Overview:
- Serial pattern transmitter: takes an N-bit pattern and shifts it out one bit per clock on a single-bit line, MSB first, optionally repeated with idle gaps.
- Transmit-side counterpart of the team's serial sequence detector. Bit order matches a shift-left receiver that compares its last N bits to the same pattern, so a loopback produces a detection.
- Used as a stimulus/pattern source in the serial datapath.

Parameters:
- N, 6: pattern width in bits (N >= 2).
- GAP, 2: idle cycles (line driven 0) between repeated frames; 0 means frames are back-to-back.
- REP_W, 4: width of the repeat-count input.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to transmit; accepted only when ready=1.
- seq  input  N  pattern to send; sampled only at acceptance.
- rep  input  REP_W  number of frames to send; 0 is treated as 1.
- a  output  1  serial data out, registered.
- ready  output  1  high in IDLE; start is accepted this cycle.
- busy  output  1  high in SEND or GAP.
- done  output  1  one-cycle pulse when the last frame completes.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values: a=0, ready=1, busy=0, done=0; state=IDLE; shift register, bit counter, gap counter and repeat counter all 0.
- All outputs are registered. ready = (state==IDLE). busy = ~ready.
- States:
  - IDLE: a=0. On start=1, at that edge: latch seq into shreg and pattern hold register; rep_left = (rep==0) ? 1 : rep; bit_cnt=0; go to SEND.
  - SEND: a = current MSB of shreg. Each cycle shift shreg left (fill 0) and increment bit_cnt. After the last bit's cycle (bit_cnt==N-1):
    - rep_left>1 and GAP>0: decrement rep_left, clear gap_cnt, go to GAP.
    - rep_left>1 and GAP==0: decrement rep_left, reload shreg from the hold register, stay in SEND with no idle cycle.
    - rep_left==1: go to IDLE and assert done for exactly that first IDLE cycle.
  - GAP: a=0 for exactly GAP cycles, then reload shreg from the hold register, bit_cnt=0, go to SEND.
- Latency, with start accepted at edge k:
  - a = seq[N-1] in the cycle after edge k, then seq[N-2] … seq[0] on successive cycles.
  - One frame with rep<=1: done high and ready high in cycle k+N+1.
  - Total busy cycles = N*R + GAP*(R-1), where R is the effective repeat count.
- start while busy: ignored, no queuing.
- seq and rep changes while busy: ignored.
- start in the done cycle: accepted, since ready=1. done and acceptance coincide, and the new frame begins the next cycle.
- Reset mid-frame: next cycle is IDLE with a=0, ready=1, done=0. No partial done is produced.
- Counter widths: bit_cnt $clog2(N); gap_cnt $clog2(GAP+1), min 1; rep_left REP_W. No wrap-around is possible because every counter is bounded by its reload value.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - After bit seq[0] of every frame, one extra SEND cycle drives the even-parity bit a = ^seq (the latched value).
  - Frame length becomes N+1; the GAP and done timing shift by one cycle per frame.
  - Total busy cycles = (N+1)*R + GAP*(R-1).
- Undefined: no parity bit; frame length is N. No parity logic is synthesized.

Test Plan:
- N=6, seq=6'b101100, rep=1, start pulse at cycle 0 -> a = 1,0,1,1,0,0 in cycles 1–6; done=1 and ready=1 in cycle 7 only; a=0 in cycle 7.
- seq=6'b110011, rep=3, GAP=2 -> three frames separated by exactly two a=0 cycles; busy for 22 cycles; a single done pulse in cycle 23.
- rep=0, seq=6'b000001 -> identical to rep=1: one frame, done in cycle 7; start held high while busy causes no second frame until the done cycle.
- reset asserted in cycle 3 (third bit) -> from cycle 4: a=0, ready=1, busy=0; done never pulses; a new start afterwards sends the full pattern.
- Loopback into the sequence detector with the same seq=6'b101101, rep=2, GAP=0 -> detector valid pulses after each completed frame; transmitter done one cycle after the last bit.
- SEQ_TX_PARITY_EN defined, seq=6'b101100 -> a = 1,0,1,1,0,0,1 in cycles 1–7; done in cycle 8.
